// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track phase, MSB-first bit trials
// against a synchronized comparator, one-cycle done pulse with held result.
module sar_adc_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       chan,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [2:0]       chan_sel,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CMAX  = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CNT_W = $clog2(CMAX);
  localparam int BIT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_CONVERT, ST_DONE} state_t;

  state_t             state;
  logic               cmp_meta, cmp_s;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [WIDTH-1:0]   mask_cur;
  logic [WIDTH-1:0]   decided;

  // The bit under trial is always set in dac_code, so "keep" is dac_code itself.
  always_comb begin
    mask_cur = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;
    decided  = cmp_s ? dac_code : (dac_code & ~mask_cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_meta  <= 1'b0;
      cmp_s     <= 1'b0;
    end else begin
      cmp_meta  <= cmp_in;
      cmp_s     <= cmp_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      chan_sel  <= '0;
      sample_en <= 1'b0;
      dac_code  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SAMPLE;
            chan_sel  <= chan;
            sample_en <= 1'b1;
            busy      <= 1'b1;
            dac_code  <= '0;
            cnt       <= '0;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state     <= ST_IDLE;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            dac_code  <= '0;
          end else if (cnt == CNT_W'(SAMPLE_CYC - 1)) begin
            state     <= ST_CONVERT;
            sample_en <= 1'b0;
            cnt       <= '0;
            bit_idx   <= BIT_W'(WIDTH - 1);
            dac_code  <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          if (abort) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dac_code <= '0;
          end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            cnt <= '0;
            if (bit_idx == '0) begin
              state    <= ST_DONE;
              dac_code <= decided;
              result   <= decided;
              done     <= 1'b1;
            end else begin
              dac_code <= decided | (mask_cur >> 1);
              bit_idx  <= bit_idx - BIT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          dac_code <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomized bench for sar_adc_ctrl: ideal comparator driven by vin, results
// and trial codes predicted by a binary-search model of the conversion.
module tb_sar_adc_ctrl;

  localparam int W   = 8;
  localparam int SC  = 2;
  localparam int ST  = 4;
  localparam int LAT = SC + W * ST + 1;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [2:0]   chan, chan_sel;
  logic         sample_en, busy, done;
  logic [W-1:0] dac_code, result, vin;
  logic         cmp_in;

  int n_tests = 0;
  int n_fail  = 0;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYC(SC), .SETTLE_CYC(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .chan(chan), .abort(abort),
    .cmp_in(cmp_in), .chan_sel(chan_sel), .sample_en(sample_en),
    .dac_code(dac_code), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  assign cmp_in = (vin >= dac_code);

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Binary search on the ideal comparator: trial k = decided bits | (1<<k).
  function automatic int trial_code(input int v, input int k);
    int dec = 0;
    for (int b = W - 1; b > k; b--)
      if (v >= (dec | (1 << b))) dec = dec | (1 << b);
    return dec | (1 << k);
  endfunction

  // Full conversion from idle; start seen at edge N, loop index c is cycle N+c.
  task automatic conv(input int v, input int ch, input bit repulse);
    int nd = 0;
    vin = W'(v); chan = 3'(ch); start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      if (c == 1) chk("chan_sel", chan_sel, ch);
      chk("sample_en", sample_en, (c <= SC) ? 1 : 0);
      chk("busy", busy, (c <= LAT) ? 1 : 0);
      if (c > SC && c <= SC + W * ST && (c - SC - 1) % ST == 0)
        chk("trial", dac_code, trial_code(v, W - 1 - (c - SC - 1) / ST));
      if (done) begin
        nd++;
        chk("done_cyc", c, LAT);
        chk("result", result, v);
      end
      if (c == LAT) chk("dac_final", dac_code, v);
      if (c == LAT + 1) chk("dac_idle", dac_code, 0);
      start = repulse && (c == 3 || c == 20);
      cyc();
      start = 1'b0;
    end
    chk("done_count", nd, 1);
  endtask

  initial begin
    int nd, last, v, ch;
    rst = 1'b1; start = 1'b0; abort = 1'b0; chan = '0; vin = '0;
    cyc(); cyc();
    chk("rst_chan", chan_sel, 0);
    chk("rst_samp", sample_en, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    rst = 1'b0;

    // First edge out of reset accepts the start.
    conv(8'hA5, 5, 1'b0);
    conv(8'h00, 2, 1'b0);
    conv(8'hFF, 7, 1'b0);
    conv(8'hA5, 5, 1'b1);

    // Abort mid-conversion: start at edge N, abort driven during cycle N+12.
    vin = 8'h3C; chan = 3'd1; start = 1'b1;
    cyc(); start = 1'b0;
    for (int c = 1; c < 12; c++) cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dac", dac_code, 0);
    chk("abort_res", result, 8'hA5);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) nd++;
      cyc();
    end
    chk("abort_nodone", nd, 0);
    chk("abort_res2", result, 8'hA5);

    // Reset mid-conversion: rst driven during cycle N+20.
    vin = 8'h77; chan = 3'd6; start = 1'b1;
    cyc(); start = 1'b0;
    for (int c = 1; c < 20; c++) cyc();
    rst = 1'b1; cyc();
    chk("mrst_chan", chan_sel, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dac", dac_code, 0);
    chk("mrst_done", done, 0);
    chk("mrst_res", result, 0);
    chk("mrst_samp", sample_en, 0);
    rst = 1'b0;
    conv(8'h77, 6, 1'b0);

    for (int i = 0; i < 20; i++) begin
      v  = int'($urandom_range(0, 255));
      ch = int'($urandom_range(0, 7));
      conv(v, ch, (i % 4) == 0);
    end

    // Start held: done pulses every LAT+1 cycles.
    vin = 8'h5A; chan = 3'd3; start = 1'b1;
    nd = 0; last = 0;
    cyc();
    for (int c = 1; c <= 150; c++) begin
      if (done) begin
        nd++;
        chk("b2b_res", result, 8'h5A);
        chk("b2b_gap", c - last, (nd == 1) ? LAT : LAT + 1);
        last = c;
      end
      cyc();
    end
    chk("b2b_count", nd, 4);
    start = 1'b0;
    for (int c = 0; c < 40; c++) cyc();
    chk("b2b_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: conversion resolution in bits, legal range 2..12.
REQ-002 SHALL have parameter SAMPLE_CYC, default 2: track-phase length in cycles, minimum 1.
REQ-003 SHALL have parameter SETTLE_CYC, default 4: cycles per bit trial, minimum 3.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  conversion request; sampled in IDLE only.
REQ-007 chan  in  3  analog mux channel; captured on an accepted start.
REQ-008 abort  in  1  terminate conversion; takes effect at the next edge.
REQ-009 cmp_in  in  1  asynchronous comparator output from the analog pad; 1 = Vin >= Vdac.
REQ-010 chan_sel  out  3  latched channel driven to the analog mux.
REQ-011 sample_en  out  1  track switch enable; high only in SAMPLE.
REQ-012 dac_code  out  WIDTH  code driven to the capacitive DAC.
REQ-013 busy  out  1  high in SAMPLE, CONVERT and DONE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 result  out  WIDTH  last completed conversion; held until the next done.

Function
REQ-016 cmp_in SHALL pass through a 2-flop synchronizer (cmp_s) before any use.
REQ-017 SHALL implement four states:
- IDLE
- SAMPLE
- CONVERT
- DONE
REQ-018 IDLE: start=1 -> SAMPLE; chan captured into chan_sel at the same edge; otherwise stay.
REQ-019 SAMPLE SHALL last exactly SAMPLE_CYC cycles, with sample_en=1 and dac_code=0, then -> CONVERT.
REQ-020 CONVERT SHALL process bits MSB to LSB, SETTLE_CYC cycles each, for WIDTH*SETTLE_CYC cycles total.
REQ-021 During a bit-k trial, dac_code SHALL equal the decided upper bits, with bit k=1 and the lower bits 0.
REQ-022 On the last cycle of each trial, bit k SHALL be kept if cmp_s=1 and cleared if cmp_s=0.
REQ-023 After the LSB decision -> DONE.
REQ-024 DONE SHALL last 1 cycle:
- done=1
- result loaded with the final code
- dac_code = final code
- then -> IDLE
REQ-025 Latency: with start accepted at edge N, done SHALL be high in cycle N+SAMPLE_CYC+WIDTH*SETTLE_CYC+1, and result SHALL be valid from that same cycle.
REQ-026 In IDLE, dac_code SHALL be 0 and busy SHALL be 0; chan_sel holds its last value.
REQ-027 start SHALL be ignored while busy=1, with no queuing.
REQ-028 start=1 held continuously SHALL begin a new conversion on the first IDLE cycle after DONE (back-to-back, 1 idle cycle).
REQ-029 abort=1 in SAMPLE or CONVERT SHALL force IDLE at the next edge:
- no done pulse
- result unchanged
- dac_code=0 and busy=0 from the next cycle
REQ-030 abort in IDLE or DONE SHALL have no effect; DONE still completes.
REQ-031 abort and start both high in IDLE SHALL give start priority: the conversion begins.
REQ-032 The bit counter and settle counter SHALL be sized for WIDTH and SETTLE_CYC and SHALL never wrap within a conversion.

Reset
REQ-033 rst=1 at any edge SHALL force IDLE, including mid-conversion, and SHALL set:
- chan_sel=0
- sample_en=0
- dac_code=0
- busy=0
- done=0
- result=0
- both synchronizer flops = 0
REQ-034 The first start SHALL be accepted on the first edge with rst=0.

Verification
(defaults WIDTH=8, SAMPLE_CYC=2, SETTLE_CYC=4; comparator model cmp_in = (vin >= dac_code))
REQ-035 vin=0xA5, chan=5, start pulse at edge N -> the bench SHALL observe:
- chan_sel=5 from N+1
- sample_en high for cycles N+1..N+2
- done at N+35 with result=0xA5
- dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5
REQ-036 vin=0x00 -> result=0x00; vin=0xFF -> result=0xFF; each completes with exactly one done pulse.
REQ-037 start re-pulsed at cycles N+3 and N+20 of a conversion -> ignored; exactly one done at N+35.
REQ-038 abort at cycle N+12 after a start with vin=0x3C, previous result 0xA5 -> the bench SHALL observe:
- busy=0 and dac_code=0 at N+13
- no done pulse
- result stays 0xA5
REQ-039 rst=1 for 1 cycle at N+20 -> the bench SHALL observe:
- all outputs reset at N+21
- no done pulse
- a new start then yields the correct result at the REQ-025 latency
REQ-040 start held high, vin=0x5A -> done pulses every 36 cycles, each with result=0x5A.
